// File: rtl/spectrum_reader.sv
// spectrum_reader: drains FFT re/im pairs from SDRAM, streams alpha-max-plus-beta-min bin magnitudes; define SPECTRUM_READER_PEAK_EN for per-frame peak tracking
module spectrum_reader #(
  parameter int          NUM_BINS  = 512,
  parameter logic [31:0] RE_BASE   = 32'h4000,
  parameter logic [31:0] IM_BASE   = 32'h5000,
  parameter int          MAG_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  output logic        slave_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic        master_waitrequest,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        bin_valid,
  input  logic        bin_ready,
  output logic [9:0]  bin_index,
  output logic [15:0] bin_mag
);
  typedef enum logic [2:0] {IDLE, REQ_RE, WAIT_RE, REQ_IM, WAIT_IM, EMIT, DONE} state_t;
  state_t state, state_nxt;
  logic [9:0] idx;
  logic [31:0] re, a, b, mx, mn, peak_word;
  logic [32:0] raw, shifted;
  logic [15:0] mag;
  logic busy, done, start, last, unused_ok;
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x == 32'h8000_0000 ? 32'h7FFF_FFFF : (x[31] ? -x : x);
  endfunction
  assign start = slave_write && slave_address == 4'd0;
  assign last = idx == 10'(NUM_BINS - 1);
  assign unused_ok = ^slave_writedata;
  assign slave_waitrequest = 1'b0;
  assign master_read = state == REQ_RE || state == REQ_IM;
  assign master_address = (state == REQ_IM ? IM_BASE : RE_BASE) + {20'b0, idx, 2'b00};
  assign bin_valid = state == EMIT;
  assign bin_index = idx;
  assign slave_readdata = !slave_read ? 32'd0 :
                          slave_address == 4'd1 ? {30'b0, done, busy} :
                          slave_address == 4'd2 ? peak_word : 32'd0;
  // -2^31 has no positive twin, so abs32 clamps it to 2^31-1
  always_comb begin
    a = abs32(re);
    b = abs32(master_readdata);
    mx = a > b ? a : b;
    mn = a > b ? b : a;
    raw = {1'b0, mx} + {2'b0, mn[31:1]};
    shifted = raw >> MAG_SHIFT;
    mag = |shifted[32:16] ? 16'hFFFF : shifted[15:0];
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? REQ_RE : IDLE;
      REQ_RE:  state_nxt = master_waitrequest ? REQ_RE : WAIT_RE;
      WAIT_RE: state_nxt = master_readdatavalid ? REQ_IM : WAIT_RE;
      REQ_IM:  state_nxt = master_waitrequest ? REQ_IM : WAIT_IM;
      WAIT_IM: state_nxt = master_readdatavalid ? EMIT : WAIT_IM;
      EMIT:    state_nxt = !bin_ready ? EMIT : (last ? DONE : REQ_RE);
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      re <= '0;
      bin_mag <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        idx <= '0;
        busy <= 1'b1;
        done <= 1'b0;
      end
      if (state == WAIT_RE && master_readdatavalid) re <= master_readdata;
      if (state == WAIT_IM && master_readdatavalid) bin_mag <= mag;
      if (state == EMIT && bin_ready && !last) idx <= idx + 10'd1;
      if (state == DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
`ifdef SPECTRUM_READER_PEAK_EN
  logic [15:0] peak_mag;
  logic [9:0] peak_idx;
  // strict compare keeps the earliest bin on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_mag <= '0;
      peak_idx <= '0;
    end else if (state == IDLE && start) begin
      peak_mag <= '0;
      peak_idx <= '0;
    end else if (state == EMIT && bin_ready && bin_mag > peak_mag) begin
      peak_mag <= bin_mag;
      peak_idx <= idx;
    end
  end
  assign peak_word = {6'b0, peak_idx, peak_mag};
`else
  assign peak_word = 32'd0;
`endif
endmodule

// File: tb/tb_spectrum_reader.sv
// tb_spectrum_reader: directed frames against an Avalon-MM memory responder with hand-computed magnitudes
module tb_spectrum_reader;
  localparam int N = 512;
  localparam logic [31:0] RE_BASE = 32'h4000;
  localparam logic [31:0] IM_BASE = 32'h5000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] slave_address = '0;
  logic slave_read = 1'b0, slave_write = 1'b0;
  logic [31:0] slave_writedata = '0, slave_readdata;
  logic slave_waitrequest;
  logic [31:0] master_address, master_readdata;
  logic master_read, master_waitrequest, master_readdatavalid;
  logic bin_valid, bin_ready;
  logic [9:0] bin_index;
  logic [15:0] bin_mag;
  int n_chk = 0, n_pass = 0;
  int ws = 0, dly = 0, acc = 0, stray = 0, cyc, k;
  bit watch = 0, ok;
  logic [31:0] re_mem [N];
  logic [31:0] im_mem [N];
  logic [15:0] exp_mag [N];
  logic [25:0] cap_q [$];
  logic [31:0] ra, d;
  spectrum_reader dut (
    .clk(clk), .rst_n(rst_n),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .slave_waitrequest(slave_waitrequest),
    .master_address(master_address), .master_read(master_read),
    .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_index(bin_index), .bin_mag(bin_mag)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic csr_rd(input logic [3:0] a, output logic [31:0] v);
    slave_address = a;
    slave_read = 1'b1;
    #1 v = slave_readdata;
    slave_read = 1'b0;
    slave_address = '0;
  endtask
  task automatic start();
    slave_address = '0;
    slave_write = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask
  task automatic wait_done(output int c);
    logic [31:0] v;
    c = 1;
    forever begin
      csr_rd(4'd1, v);
      if (v[1] || c > 30000) break;
      @(posedge clk); #1;
      c++;
    end
  endtask
  task automatic wait_bin(input int b, output bit found);
    int t = 0;
    while (!(bin_valid && bin_index == 10'(b)) && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    found = t < 20000;
  endtask
  task automatic check_bins(input int cnt);
    check("bin_count", cap_q.size(), cnt);
    for (int i = 0; i < cnt && i < cap_q.size(); i++)
      check($sformatf("bin%0d", i), {6'b0, cap_q[i]}, {6'b0, 10'(i), exp_mag[i]});
  endtask
  task automatic fill_ramp();
    for (int i = 0; i < N; i++) begin
      re_mem[i] = 32'(i) << 8;
      im_mem[i] = '0;
      exp_mag[i] = 16'(i);
    end
    re_mem[3] = 32'h8000_0000; im_mem[3] = 32'h8000_0000; exp_mag[3] = 16'hFFFF;
    re_mem[5] = 32'h0000_0300; im_mem[5] = 32'hFFFF_FC00; exp_mag[5] = 16'h0005;
    re_mem[9] = 32'hFFFF_F000; im_mem[9] = 32'h0000_0800; exp_mag[9] = 16'h0014;
    re_mem[10] = 32'h7FFF_FFFF; exp_mag[10] = 16'hFFFF;
    re_mem[11] = 32'h00FF_FF00; exp_mag[11] = 16'hFFFF;
    re_mem[12] = 32'h0100_0000; exp_mag[12] = 16'hFFFF;
    re_mem[13] = 32'h0001_FE00; im_mem[13] = 32'h0001_FE00; exp_mag[13] = 16'h02FD;
  endtask
  // memory responder: ws wait cycles per request, data valid dly cycles after accept
  initial begin
    master_waitrequest = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata = '0;
    forever begin
      if (!master_read) begin
        @(posedge clk); #1;
      end else begin
        ra = master_address;
        check("req_addr", ra, ((acc % 2) ? IM_BASE : RE_BASE) + 32'(4 * (acc / 2)));
        if (ws > 0) begin
          master_waitrequest = 1'b1;
          repeat (ws) begin
            @(posedge clk); #1;
            check("hold_addr", master_address, ra);
            check("hold_read", {31'b0, master_read}, 1);
            check("hold_valid", {31'b0, bin_valid}, 0);
          end
          master_waitrequest = 1'b0;
        end
        @(posedge clk); #1;
        acc++;
        repeat (dly) begin
          @(posedge clk); #1;
          check("one_outstanding", {31'b0, master_read}, 0);
        end
        master_readdata = ra >= IM_BASE ? im_mem[(ra - IM_BASE) >> 2] : re_mem[(ra - RE_BASE) >> 2];
        master_readdatavalid = 1'b1;
        @(posedge clk); #1;
        master_readdatavalid = 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && bin_valid && bin_ready) cap_q.push_back({bin_index, bin_mag});
    if (watch && master_read) stray++;
  end
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bin_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_read", {31'b0, master_read}, 0);
    check("rst_addr", master_address, RE_BASE);
    check("rst_valid", {31'b0, bin_valid}, 0);
    check("rst_index", {22'b0, bin_index}, 0);
    check("rst_mag", {16'b0, bin_mag}, 0);
    check("rst_waitreq", {31'b0, slave_waitrequest}, 0);
    csr_rd(4'd1, d); check("rst_status", d, 0);
    csr_rd(4'd2, d); check("rst_peak", d, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    csr_rd(4'd7, d); check("csr_other", d, 0);
    // frame 1: no stalls, exact cycle count
    fill_ramp();
    acc = 0; cap_q.delete();
    start();
    check("read_after_start", {31'b0, master_read}, 1);
    wait_done(cyc);
    check("frame_cycles", cyc, 5 * N + 2);
    csr_rd(4'd1, d); check("status_done", d, 2);
    check_bins(N);
    check("reads_f1", acc, 2 * N);
    csr_rd(4'd2, d);
`ifdef SPECTRUM_READER_PEAK_EN
    check("peak_f1", d, {6'b0, 10'd3, 16'hFFFF});
`else
    check("peak_f1", d, 0);
`endif
    // frame 2: waitrequest and read latency, output stall at bin 7
    ws = 3; dly = 4; acc = 0; cap_q.delete();
    start();
    csr_rd(4'd1, d); check("done_cleared", d, 1);
    wait_bin(6, ok); check("reach_bin6", {31'b0, ok}, 1);
    @(posedge clk); #1;
    bin_ready = 1'b0;
    wait_bin(7, ok); check("reach_bin7", {31'b0, ok}, 1);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", {31'b0, bin_valid}, 1);
      check("stall_index", {22'b0, bin_index}, 7);
      check("stall_mag", {16'b0, bin_mag}, 7);
      check("stall_noread", {31'b0, master_read}, 0);
      @(posedge clk); #1;
    end
    bin_ready = 1'b1;
    wait_done(cyc);
    check("frame2_done", {31'b0, cyc <= 30000}, 1);
    check_bins(N);
    check("reads_f2", acc, 2 * N);
    // frame 3: restart ignored mid-frame, async reset aborts at bin 100
    ws = 0; dly = 0; acc = 0; cap_q.delete();
    start();
    wait_bin(50, ok); check("reach_bin50", {31'b0, ok}, 1);
    start();
    csr_rd(4'd1, d); check("busy_midframe", d, 1);
    wait_bin(100, ok); check("reach_bin100", {31'b0, ok}, 1);
    watch = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'b0, bin_valid}, 0);
    check("abort_index", {22'b0, bin_index}, 0);
    check("abort_mag", {16'b0, bin_mag}, 0);
    check("abort_addr", master_address, RE_BASE);
    csr_rd(4'd1, d); check("abort_status", d, 0);
    csr_rd(4'd2, d); check("abort_peak", d, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    watch = 1'b0;
    check("no_read_after_abort", stray, 0);
    check_bins(100);
    // frame 4: equal peaks at bins 20 and 40
    for (int i = 0; i < N; i++) begin
      re_mem[i] = '0;
      im_mem[i] = '0;
    end
    re_mem[20] = 32'h5000;
    re_mem[30] = 32'hFFFF_C000;
    re_mem[40] = 32'h5000;
    acc = 0; cap_q.delete();
    start();
    wait_done(cyc);
    check("frame4_cycles", cyc, 5 * N + 2);
    check("f4_bin20", {6'b0, cap_q[20]}, {6'b0, 10'd20, 16'h0050});
    check("f4_bin30", {6'b0, cap_q[30]}, {6'b0, 10'd30, 16'h0040});
    csr_rd(4'd2, d);
`ifdef SPECTRUM_READER_PEAK_EN
    check("peak_f4", d, {6'b0, 10'd20, 16'h0050});
`else
    check("peak_f4", d, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
